// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// framing constants used by the transmitter and its controllers.
package uart_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_START     = 4'b0010,
      ST_WAIT_DONE = 4'b0100,
      ST_WAIT_CLR  = 4'b1000
   } state_t;

   localparam logic [15:0] BAUD_DIV_DEFAULT = 16'h43D;
   localparam int          FRAME_BITS       = 10;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request bit at or after ptr,
// wrapping modulo N_REQ.
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] sel,
   output logic [N_REQ-1:0] onehot,
   output logic             any_valid
);

   always_comb begin : pick
      int               idx;
      logic [PTR_W-1:0] idx_w;
      sel       = '0;
      onehot    = '0;
      any_valid = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         idx_w = idx[PTR_W-1:0];
         if (!any_valid && req[idx_w]) begin
            any_valid     = 1'b1;
            sel           = idx_w;
            onehot[idx_w] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single uart_tx: grants one byte per transaction,
// waits for tx_done to clear, and flags a transmitter that never finishes.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TO_W        = 24,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   output logic               timeout_err,
   input  logic               err_clr
);

   localparam int               PTR_W   = $clog2(N_REQ);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   sel_q, sel_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   req_ready_q, req_ready_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [TO_W-1:0]    timer_q, timer_d;
   logic               tx_start_q, tx_start_d;
   logic               timeout_err_q, timeout_err_d;
   logic               timeout_set;

   logic [PTR_W-1:0]   pick_sel;
   logic [N_REQ-1:0]   pick_onehot;
   logic               pick_any;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      if (int'(i) == N_REQ - 1) begin
         return '0;
      end
      return i + 1'b1;
   endfunction

   uart_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_q),
      .sel       (pick_sel),
      .onehot    (pick_onehot),
      .any_valid (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      tx_data_d   = tx_data_q;
      timer_d     = timer_q;
      tx_start_d  = 1'b0;
      req_ready_d = '0;
      timeout_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // tx_done still high means uart_tx has not yet returned to idle
            if (pick_any && !tx_done) begin
               sel_d       = pick_sel;
               grant_d     = pick_onehot;
               tx_data_d   = req_data[{pick_sel, 3'b000} +: 8];
               tx_start_d  = 1'b1;
               req_ready_d = pick_onehot;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            timer_d = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            timer_d = timer_q + 1'b1;
            if (tx_done) begin
               state_d = ST_WAIT_CLR;
            end else if (timer_q == TO_LAST) begin
               timeout_set = 1'b1;
               grant_d     = '0;
               ptr_d       = wrap_inc(sel_q);
               state_d     = ST_IDLE;
            end
         end
         ST_WAIT_CLR: begin
            if (!tx_done) begin
               grant_d = '0;
               ptr_d   = wrap_inc(sel_q);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         sel_q         <= '0;
         grant_q       <= '0;
         req_ready_q   <= '0;
         tx_data_q     <= 8'h00;
         timer_q       <= '0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         sel_q         <= sel_d;
         grant_q       <= grant_d;
         req_ready_q   <= req_ready_d;
         tx_data_q     <= tx_data_d;
         timer_q       <= timer_d;
         tx_start_q    <= tx_start_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign grant       = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter that
// raises tx_done a fixed number of cycles after each tx_start.
module tb_uart_tx_arbiter;

   localparam int N_REQ       = 4;
   localparam int TO_W        = 24;
   localparam int TIMEOUT_CYC = 100;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req_valid = 4'b0000;
   logic [31:0]  req_data = 32'h4443_4241;
   logic [3:0]   req_ready;
   logic [3:0]   grant;
   logic         busy;
   logic         tx_start;
   logic [7:0]   tx_data;
   logic         tx_done;
   logic         timeout_err;
   logic         err_clr = 1'b0;

   logic         model_done = 1'b0;
   logic         man_done = 1'b0;
   bit           model_en = 1'b1;
   int           frame_len = 40;
   int           done_hold = 1;

   int           n_tests = 0;
   int           n_fail = 0;
   int           n_start = 0;
   int           n_overlap = 0;
   int           n_ready [4] = '{0, 0, 0, 0};

   assign tx_done = model_done | man_done;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ       (N_REQ),
      .TO_W        (TO_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .grant       (grant),
      .busy        (busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   // Transmitter stand-in: changes tx_done on the falling edge only.
   initial begin
      forever begin
         @(negedge clk);
         if (model_en && tx_start) begin
            repeat (frame_len) @(negedge clk);
            model_done = 1'b1;
            repeat (done_hold) @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (tx_start) n_start <= n_start + 1;
      if (tx_start && tx_done) n_overlap <= n_overlap + 1;
      for (int i = 0; i < 4; i++) begin
         if (req_ready[i]) n_ready[i] <= n_ready[i] + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000ns, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      int cnt = 0;
      do begin
         tick(1);
         cnt++;
      end while (!tx_start && cnt < budget);
      ok = tx_start;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int cnt = 0;
      do begin
         tick(1);
         cnt++;
      end while (busy && cnt < budget);
      ok = !busy;
   endtask

   task automatic test_reset();
      tick(3);
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0000", req_ready); end
      n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b required 0000", grant); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
      n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_round_robin();
      int         r0 [4];
      int         ov0;
      bit         ok;
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      for (int i = 0; i < 4; i++) r0[i] = n_ready[i];
      ov0       = n_overlap;
      req_data  = 32'h4443_4241;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_start(200, ok);
         exp_g = 4'b0001 << (k % 4);
         exp_d = 8'h41 + 8'(k % 4);
         n_tests++; if (!ok || grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b required %b (start seen %0d)", k, grant, exp_g, ok); end
         n_tests++; if (tx_data !== exp_d) begin n_fail++; $display("FAIL rr_tx_data[%0d]: got %h required %h", k, tx_data, exp_d); end
         if (k == 4) req_valid = 4'b0000;
      end
      wait_idle(200, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_idle: got busy=%b required 0", busy); end
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (n_ready[i] - r0[i] !== ((i == 0) ? 2 : 1)) begin n_fail++; $display("FAIL rr_ready_count[%0d]: got %0d required %0d", i, n_ready[i] - r0[i], (i == 0) ? 2 : 1); end
      end
      n_tests++; if (n_overlap !== ov0) begin n_fail++; $display("FAIL rr_overlap: got %0d required %0d", n_overlap, ov0); end
   endtask

   task automatic test_single();
      int r2;
      int s0;
      int cnt;
      bit busy_hi;
      r2 = n_ready[2];
      s0 = n_start;
      req_data[23:16] = 8'h4E;
      req_valid = 4'b0100;
      tick(1);
      n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b required 0100", grant); end
      n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_tx_start: got %b required 1", tx_start); end
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b required 0100", req_ready); end
      n_tests++; if (tx_data !== 8'h4E) begin n_fail++; $display("FAIL single_tx_data: got %h required 4e", tx_data); end
      req_valid = 4'b0000;
      cnt = 0;
      while (!tx_done && cnt < 200) begin tick(1); cnt++; end
      busy_hi = busy;
      while (tx_done && cnt < 200) begin busy_hi = busy; tick(1); cnt++; end
      n_tests++; if (busy_hi !== 1'b1) begin n_fail++; $display("FAIL single_busy_during_done: got %b required 1", busy_hi); end
      n_tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL single_release: got busy=%b grant=%b required busy=0 grant=0000", busy, grant); end
      tick(2);
      n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d required 1", n_start - s0); end
      n_tests++; if (n_ready[2] - r2 !== 1) begin n_fail++; $display("FAIL single_ready_count: got %0d required 1", n_ready[2] - r2); end
   endtask

   task automatic test_fairness();
      bit ok;
      req_valid = 4'b0001;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL fair_first: got %b required 0001", grant); end
      req_valid = 4'b1001;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b1000) begin n_fail++; $display("FAIL fair_yield: got %b required 1000", grant); end
      req_valid = 4'b0001;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL fair_return: got %b required 0001", grant); end
      req_valid = 4'b0000;
      wait_idle(200, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL fair_idle: got busy=%b required 0", busy); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int s0;
      int ov0;
      int hi;
      int cnt;
      done_hold = 3;
      ov0 = n_overlap;
      req_valid = 4'b0010;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL b2b_first: got %b required 0010", grant); end
      req_valid = 4'b0100;
      cnt = 0;
      while (!tx_done && cnt < 200) begin tick(1); cnt++; end
      s0 = n_start;
      hi = 0;
      while (tx_done && hi < 20) begin tick(1); hi++; end
      n_tests++; if (hi !== 3) begin n_fail++; $display("FAIL b2b_done_len: got %0d required 3", hi); end
      // first edge seeing tx_done low enters IDLE, the next one issues START
      cnt = 1;
      while (!tx_start && cnt < 20) begin tick(1); cnt++; end
      n_tests++; if (cnt !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d required 2", cnt); end
      n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL b2b_second: got %b required 0100", grant); end
      req_valid = 4'b0000;
      tick(1);
      n_tests++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL b2b_start_count: got %0d required 1", n_start - s0); end
      wait_idle(200, ok);
      n_tests++; if (!ok || n_overlap !== ov0) begin n_fail++; $display("FAIL b2b_overlap: got %0d required %0d", n_overlap, ov0); end
      done_hold = 1;
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      model_en = 1'b0;
      req_valid = 4'b1000;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b1000) begin n_fail++; $display("FAIL to_grant: got %b required 1000", grant); end
      req_valid = 4'b0000;
      // timer counts 0..99 across 100 WAIT_DONE cycles; flag lands on the edge after
      cnt = 0;
      do begin tick(1); cnt++; end while (!timeout_err && cnt < 300);
      n_tests++; if (cnt !== TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL to_latency: got %0d required %0d", cnt, TIMEOUT_CYC + 1); end
      n_tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL to_release: got grant=%b busy=%b required 0000/0", grant, busy); end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b required 0", timeout_err); end
      req_valid = 4'b0100;
      wait_start(200, ok);
      req_valid = 4'b0000;
      tick(TIMEOUT_CYC);
      n_tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_pre_second: got err=%b busy=%b required 0/1", timeout_err, busy); end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      n_tests++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_set_wins: got err=%b busy=%b required 1/0", timeout_err, busy); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      req_valid = 4'b1000;
      wait_start(200, ok);
      n_tests++; if (!ok || grant !== 4'b1000) begin n_fail++; $display("FAIL rmid_grant: got %b required 1000", grant); end
      req_valid = 4'b0000;
      tick(5);
      req_valid = 4'b1010;
      #2 rst = 1'b0;
      #1;
      n_tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_state: got busy=%b grant=%b required 0/0000", busy, grant); end
      n_tests++; if (tx_data !== 8'h00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got data=%h err=%b required 00/0", tx_data, timeout_err); end
      n_tests++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_pulses: got start=%b ready=%b required 0/0000", tx_start, req_ready); end
      tick(2);
      model_en = 1'b1;
      rst = 1'b1;
      tick(1);
      n_tests++; if (tx_start !== 1'b1 || grant !== 4'b0010) begin n_fail++; $display("FAIL rmid_ptr0: got start=%b grant=%b required 1/0010", tx_start, grant); end
      req_valid = 4'b0000;
      wait_idle(200, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_idle: got busy=%b required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_fairness();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
